// File: rtl/simplez_uart_tx_port.sv
// Memory-mapped 8N1 serial transmitter for the Simplez I/O window: one write starts a frame, reads are registered (1 cycle).
// No backpressure: software polls status.ready; a write while busy is dropped and latched in the sticky overrun flag.
module simplez_uart_tx_port #(
  parameter int                DATAW       = 12,
  parameter int                ADDRW       = 9,
  parameter logic [ADDRW-1:0]  ADDR_STATUS = 9'd508,
  parameter logic [ADDRW-1:0]  ADDR_DATA   = 9'd509,
  parameter int                BAUD_DIV    = 104
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADDRW-1:0] addr,
  input  logic [DATAW-1:0] data_in,
  input  logic             wr,
  input  logic             rd,
  output logic [DATAW-1:0] data_out,
  output logic             tx
);

  localparam int BCW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
  // The frame leaves STOP one cycle early so that a write on the final stop-bit
  // cycle starts the next frame with no idle gap; tx stays high through IDLE.
  localparam logic [BCW-1:0] STOP_LAST = BCW'(BAUD_DIV - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  logic [7:0]       holding;
  logic [7:0]       shift;
  logic [BCW-1:0]   baud_cnt;
  logic [2:0]       bit_cnt;
  logic             overrun;

  logic             sel_st;
  logic             sel_dt;
  logic             ready;
  logic             wr_acc;
  logic             wr_rej;
  logic [DATAW-1:0] status_word;
  logic [DATAW-1:0] hold_word;
  logic             unused_hi;

  assign sel_st      = (addr == ADDR_STATUS);
  assign sel_dt      = (addr == ADDR_DATA);
  assign ready       = (state == IDLE);
  assign wr_acc      = wr && sel_dt && ready;
  assign wr_rej      = wr && sel_dt && !ready;
  assign status_word = {{(DATAW-2){1'b0}}, overrun, ready};
  assign hold_word   = {{(DATAW-8){1'b0}}, holding};
  assign unused_hi   = ^data_in[DATAW-1:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      data_out <= '0;
      holding  <= '0;
      shift    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      overrun  <= 1'b0;
    end else begin
      if (rd && sel_st) begin
        data_out <= status_word;
      end else if (rd && sel_dt) begin
        data_out <= hold_word;
      end else begin
        data_out <= '0;
      end

      // A rejected write beats the clear-on-read of the same edge.
      if (wr_rej) begin
        overrun <= 1'b1;
      end else if (rd && sel_st) begin
        overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (wr_acc) begin
            holding  <= data_in[7:0];
            shift    <= data_in[7:0];
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            tx       <= shift[0];
            shift    <= shift >> 1;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BCW'(1);
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shift[0];
              shift   <= shift >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + BCW'(1);
          end
        end
        STOP: begin
          if (baud_cnt == STOP_LAST) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + BCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/simplez_uart_tx_port.md
# simplez_uart_tx_port

Memory-mapped serial output peripheral for the Simplez microcontroller. It sits on the CPU data/address buses next to main memory and consumes the stores (`ST`) that the CPU issues to the I/O window at the top of the 512-word address space. It serialises each written byte as 8N1 on a `tx` pin. It exposes a status word the program polls before writing.

## Interface
- `DATAW`, default 12: data bus width.
- `ADDRW`, default 9: address bus width.
- `ADDR_STATUS`, default 9'd508: status register address (read only).
- `ADDR_DATA`, default 9'd509: transmit data register address (read/write).
- `BAUD_DIV`, default 104: clock cycles per serial bit; must be ≥ 2.

- `clk`, input, 1: system clock; all state updates on the rising edge.
- `rst`, input, 1: one clock; reset is synchronous and active-high.
- `addr`, input, ADDRW: address bus (from RA).
- `data_in`, input, DATAW: CPU write data. Bits [DATAW-1:8] are ignored.
- `wr`, input, 1: write strobe (`esc`).
- `rd`, input, 1: read strobe (`lec`).
- `data_out`, output, DATAW: registered read data. It is zero when the port is not selected, so it can be OR-ed onto the bus with memory.
- `tx`, output, 1: serial line. Idles high.

## Operation
- **Address decode.** `sel_st = (addr == ADDR_STATUS)`, `sel_dt = (addr == ADDR_DATA)`. Any other address has no effect on internal state.
- **Status word.**
  - bit0 `ready` = 1 when the FSM is in IDLE.
  - bit1 `overrun` = sticky flag, set when a write is rejected.
  - Other bits read 0.
- **Write acceptance.** On a clock edge with `wr && sel_dt`:
  - If `ready`: latch `data_in[7:0]` into the holding register and the shift register, then go to START.
  - If not `ready`: the write is discarded and `overrun` is set. The byte in flight is unaffected.
- Writes to `ADDR_STATUS` are ignored.
- **Reads.** On a clock edge with `rd`:
  - If `sel_st`: `data_out` is loaded with the status word, and `overrun` is cleared.
  - If `sel_dt`: `data_out` is loaded with `{0, holding[7:0]}`.
  - Otherwise: `data_out` is loaded with 0.
- When `rd` = 0, `data_out` is loaded with 0.
- **FSM states:**
  - IDLE: `tx` = 1.
  - START: `tx` = 0, for BAUD_DIV cycles.
  - DATA: `tx` = shift[0]. Bits are sent LSB first. The register shifts right after each bit; the bit counter runs 0..7.
  - STOP: `tx` = 1, for BAUD_DIV cycles. Then return to IDLE.
- **Counters.**
  - Baud counter: width `$clog2(BAUD_DIV)`. Counts 0..BAUD_DIV-1, and is cleared on each write acceptance and on each bit transition.
  - Bit counter: 3 bits.
- `tx` is driven from a flop; it is never combinational.
- **Simultaneous events:**
  - Read of status in the same edge as a rejected write: `data_out` shows the pre-edge flags, and `overrun` ends set (set wins over clear).
  - Read and write of `ADDR_DATA` on the same edge: `data_out` returns the old holding value.
  - Write on the edge where STOP completes: rejected, because `ready` was still 0 before that edge.
- **Reset.** Reset mid-frame aborts the frame.
  - State returns to IDLE.
  - `tx` = 1 and `data_out` = 0.
  - Holding register = 0, `overrun` = 0, all counters = 0.

## Timing
- Reset values: `tx` = 1, `data_out` = 0, status = 0x001.
- Write accepted at edge E:
  - `tx` falls after edge E.
  - The start bit occupies cycles E+1 .. E+BAUD_DIV.
  - Data bit k occupies cycles E+1+(k+1)·BAUD_DIV .. E+(k+2)·BAUD_DIV.
  - The stop bit follows the last data bit.
- `ready` reads 0 from the edge after E and returns to 1 exactly 10·BAUD_DIV cycles after E.
- Earliest accepted back-to-back write: edge E + 10·BAUD_DIV. This gives a continuous stream with no idle gap.
- Read latency is 1 cycle: data is valid after the edge that samples `rd`. This matches the synchronous memory read.

## Test plan
- **Reset.** Assert `rst` 2 cycles mid-stream → `tx` = 1, `data_out` = 0x000. A status read then returns 0x001.
- **Single byte.** With BAUD_DIV = 4, write 0x0A5 to 509 → `tx` shows 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles. `ready` returns after exactly 40 cycles.
- **Status polling.** Read 508 during the frame → 0x000; after the frame → 0x001. Read 509 → 0x0A5.
- **Overrun.** Write 0x033 while busy → no change to the `tx` waveform.
  - First status read → 0x002.
  - Second status read (after the frame) → 0x001.
  - 0x033 is never transmitted.
- **Back-to-back.** Write 0x041 and 0x042 with the second write at exactly E + 40 (BAUD_DIV = 4) → both accepted, with no idle cycle between frames. A write at E + 39 → rejected with `overrun` set.
- **Decode and reset mid-frame.**
  - Write 0x0FF to 507 or 508 → `tx` stays 1. Reads of 507 return 0x000.
  - `rst` during data bit 3 → `tx` = 1 next cycle and stays idle.
